// File: rtl/qq_front.sv
// rtl/qq_front.sv - command front-end driving the QuickQueue node chain enq/deq strobes
module qq_front #(
  parameter int W       = 32,
  parameter int CAP     = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enq_valid,
  input  logic [W-1:0]               enq_key,
  output logic                       enq_ready,
  input  logic                       deq_valid,
  output logic                       deq_ready,
  output logic                       res_valid,
  output logic [W-1:0]               res_key,
  output logic                       res_empty,
  input  logic                       res_ready,
  output logic                       node_enq,
  output logic                       node_deq,
  output logic [W-1:0]               node_data,
  input  logic [W-1:0]               node_key,
  input  logic                       node_rdy,
  input  logic                       node_full,
  input  logic                       node_empty,
  output logic [$clog2(CAP+1)-1:0]   count,
  output logic                       timeout_err
);

  localparam int CW = $clog2(CAP + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_SETTLE,
    S_WAIT,
    S_RESP,
    S_ERR
  } state_t;

  state_t        state;
  logic          prio_deq;
  logic          op_deq;
  logic [TW-1:0] timer;

  logic idle;
  logic enq_base;
  logic deq_base;
  logic enq_go;
  logic deq_go;
  logic contested;

  // Each ready is masked only by the competing channel, never by its own valid.
  always_comb begin
    idle      = (state == S_IDLE) && !rst;
    enq_base  = idle && node_rdy && !node_full && (count < CW'(CAP)) && !timeout_err;
    deq_base  = idle && node_rdy && !timeout_err;
    enq_ready = enq_base && !(deq_valid && deq_base && prio_deq);
    deq_ready = deq_base && !(enq_valid && enq_base && !prio_deq);
    enq_go    = enq_valid && enq_ready;
    deq_go    = deq_valid && deq_ready;
    contested = enq_valid && deq_valid && enq_base && deq_base;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      prio_deq    <= 1'b1;
      op_deq      <= 1'b0;
      timer       <= '0;
      count       <= '0;
      node_enq    <= 1'b0;
      node_deq    <= 1'b0;
      node_data   <= '0;
      res_valid   <= 1'b0;
      res_key     <= '0;
      res_empty   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      node_enq <= 1'b0;
      node_deq <= 1'b0;
      case (state)
        S_IDLE: begin
          if (contested) prio_deq <= !prio_deq;
          if (enq_go) begin
            node_data <= enq_key;
            node_enq  <= 1'b1;
            count     <= count + CW'(1);
            op_deq    <= 1'b0;
            state     <= S_ISSUE;
          end else if (deq_go) begin
            op_deq <= 1'b1;
            if (count != '0 && !node_empty) begin
              // The head still holds the minimum until the strobe lands.
              node_deq  <= 1'b1;
              count     <= count - CW'(1);
              res_key   <= node_key;
              res_empty <= 1'b0;
              state     <= S_ISSUE;
            end else begin
              res_key   <= '1;
              res_empty <= 1'b1;
              res_valid <= 1'b1;
              state     <= S_RESP;
            end
          end
        end
        S_ISSUE: begin
          timer <= '0;
          state <= S_SETTLE;
        end
        S_SETTLE: state <= S_WAIT;
        S_WAIT: begin
          if (node_rdy) begin
            if (op_deq) begin
              res_valid <= 1'b1;
              state     <= S_RESP;
            end else begin
              state <= S_IDLE;
            end
          end else if (timer == TW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state       <= S_ERR;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        S_ERR:   state <= S_ERR;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qq_front.sv
// tb/tb_qq_front.sv - scoreboard bench for qq_front with a sorted-queue node model
module tb_qq_front;

  localparam int W = 32;
  localparam int CAP = 16;
  localparam int TIMEOUT = 64;

  typedef struct {
    logic [W-1:0] key;
    bit           empty;
  } res_t;

  logic         clk = 0;
  logic         rst;
  logic         enq_valid, deq_valid, res_ready;
  logic [W-1:0] enq_key;
  logic         enq_ready, deq_ready, res_valid, res_empty;
  logic [W-1:0] res_key, node_data, node_key;
  logic         node_enq, node_deq, node_rdy, node_full, node_empty;
  logic [4:0]   count;
  logic         timeout_err;

  int n_checks = 0;
  int n_pass = 0;
  int node_strobes = 0;
  int busy = 0;
  bit stall = 0;
  bit force_full = 0;
  bit stall_res = 0;
  bit exp_deq_turn = 1;
  logic [W-1:0] nq[$];
  logic [W-1:0] ref_q[$];
  res_t exp_q[$];

  qq_front #(.W(W), .CAP(CAP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_key(enq_key), .enq_ready(enq_ready),
    .deq_valid(deq_valid), .deq_ready(deq_ready),
    .res_valid(res_valid), .res_key(res_key), .res_empty(res_empty), .res_ready(res_ready),
    .node_enq(node_enq), .node_deq(node_deq), .node_data(node_data),
    .node_key(node_key), .node_rdy(node_rdy), .node_full(node_full), .node_empty(node_empty),
    .count(count), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: unordered bag of keys; a dequeue yields its minimum.
  task automatic model_grant(input bit is_enq, input logic [W-1:0] key);
    res_t r;
    int mi;
    if (is_enq) begin
      ref_q.push_back(key);
    end else if (ref_q.size() == 0) begin
      r.key = '1; r.empty = 1'b1;
      exp_q.push_back(r);
    end else begin
      mi = 0;
      foreach (ref_q[i]) if (ref_q[i] < ref_q[mi]) mi = i;
      r.key = ref_q[mi]; r.empty = 1'b0;
      exp_q.push_back(r);
      ref_q.delete(mi);
    end
  endtask

  // Node chain model: sorted storage, rdy drops after each strobe for a random time.
  initial begin
    node_rdy = 1; node_key = '1; node_full = 0; node_empty = 1;
    forever begin
      @(negedge clk);
      if (rst) begin
        nq.delete(); node_rdy = 1; busy = 0;
      end else if (node_enq || node_deq) begin
        int pos;
        node_strobes++;
        check("single_strobe", {63'd0, node_enq & node_deq}, 64'd0);
        if (node_enq) begin
          pos = 0;
          while (pos < nq.size() && nq[pos] <= node_data) pos++;
          nq.insert(pos, node_data);
        end else if (nq.size() > 0) begin
          void'(nq.pop_front());
        end
        node_rdy = 0;
        busy = $urandom_range(0, 2);
      end else if (!node_rdy && !stall) begin
        if (busy == 0) node_rdy = 1;
        else busy--;
      end
      node_key   = (nq.size() > 0) ? nq[0] : '1;
      node_empty = (nq.size() == 0);
      node_full  = force_full || (nq.size() >= CAP);
    end
  end

  // Result monitor: pops expectations on each transfer and checks hold while stalled.
  initial begin
    bit pv;
    logic [W-1:0] pk;
    bit pe;
    res_t e;
    res_ready = 0;
    pv = 0;
    forever begin
      @(negedge clk);
      res_ready = stall_res ? 1'b0 : 1'($urandom_range(0, 1));
      #1;
      if (rst) begin
        pv = 0;
      end else begin
        if (pv) begin
          check("res_hold_valid", {63'd0, res_valid}, 64'd1);
          check("res_hold_key", {32'd0, res_key}, {32'd0, pk});
          check("res_hold_empty", {63'd0, res_empty}, {63'd0, pe});
        end
        if (res_valid && res_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_result: got key %0h, expected no result", res_key);
          end else begin
            e = exp_q.pop_front();
            check("res_key", {32'd0, res_key}, {32'd0, e.key});
            check("res_empty", {63'd0, res_empty}, {63'd0, e.empty});
          end
          pv = 0;
        end else begin
          pv = res_valid; pk = res_key; pe = res_empty;
        end
      end
    end
  end

  task automatic do_cmd(input bit is_enq, input logic [W-1:0] key);
    bit g = 0;
    int t = 0;
    @(negedge clk);
    enq_valid = is_enq; deq_valid = !is_enq; enq_key = key;
    while (!g && t < 300) begin
      #1;
      if (is_enq ? enq_ready : deq_ready) g = 1;
      else begin @(negedge clk); t++; end
    end
    check(is_enq ? "enq_grant" : "deq_grant", {63'd0, g}, 64'd1);
    if (g) model_grant(is_enq, key);
    @(negedge clk);
    enq_valid = 0; deq_valid = 0;
    #1 check("count", {59'd0, count}, 64'(ref_q.size()));
  endtask

  task automatic wait_drain();
    int t = 0;
    @(negedge clk); #1;
    while (!(exp_q.size() == 0 && deq_ready) && t < 500) begin
      @(negedge clk); #1; t++;
    end
    check("drain", {63'd0, exp_q.size() == 0 && deq_ready}, 64'd1);
  endtask

  task automatic reset_dut();
    rst = 1; stall = 0; force_full = 0; enq_valid = 0; deq_valid = 0;
    ref_q.delete(); exp_q.delete(); exp_deq_turn = 1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_enq_ready", {63'd0, enq_ready}, 64'd0);
    check("rst_deq_ready", {63'd0, deq_ready}, 64'd0);
    rst = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    int s0;
    logic [W-1:0] hk;
    logic [W-1:0] k;
    bit g;
    int t;
    rst = 1; enq_valid = 0; deq_valid = 0; enq_key = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_enq_ready", {63'd0, enq_ready}, 64'd0);
    check("reset_deq_ready", {63'd0, deq_ready}, 64'd0);
    check("reset_res_valid", {63'd0, res_valid}, 64'd0);
    check("reset_res_key", {32'd0, res_key}, 64'd0);
    check("reset_node_data", {32'd0, node_data}, 64'd0);
    check("reset_strobes", {62'd0, node_enq, node_deq}, 64'd0);
    check("reset_count", {59'd0, count}, 64'd0);
    check("reset_timeout_err", {63'd0, timeout_err}, 64'd0);
    rst = 0;

    // Async reset while the enq strobe is up
    do_cmd(1, 32'h77);
    check("issue_enq_strobe", {63'd0, node_enq}, 64'd1);
    check("issue_node_data", {32'd0, node_data}, 64'h77);
    #1 rst = 1;
    #1;
    check("rst_kills_strobe", {63'd0, node_enq}, 64'd0);
    check("rst_count", {59'd0, count}, 64'd0);
    reset_dut();

    // Async reset mid-WAIT
    stall = 1;
    do_cmd(1, 32'h5);
    repeat (5) @(negedge clk);
    #1 check("wait_count", {59'd0, count}, 64'd1);
    rst = 1;
    #1;
    check("wait_rst_count", {59'd0, count}, 64'd0);
    check("wait_rst_strobes", {62'd0, node_enq, node_deq}, 64'd0);
    reset_dut();

    // Async reset while a result is held
    stall_res = 1;
    do_cmd(0, 0);
    check("resp_valid", {63'd0, res_valid}, 64'd1);
    #1 rst = 1;
    #1 check("rst_res_valid", {63'd0, res_valid}, 64'd0);
    stall_res = 0;
    reset_dut();

    // Basic ordering: 5,3,9 in, minimum first out
    s0 = node_strobes;
    do_cmd(1, 32'd5); do_cmd(1, 32'd3); do_cmd(1, 32'd9);
    repeat (3) do_cmd(0, 0);
    wait_drain();
    check("basic_strobes", 64'(node_strobes - s0), 64'd6);

    // Dequeue on empty: no strobe, held all-ones result
    s0 = node_strobes;
    stall_res = 1;
    do_cmd(0, 0);
    check("empty_res_valid", {63'd0, res_valid}, 64'd1);
    check("empty_res_key", {32'd0, res_key}, 64'hFFFF_FFFF);
    check("empty_res_flag", {63'd0, res_empty}, 64'd1);
    hk = res_key;
    repeat (4) begin
      @(negedge clk); #1;
      check("empty_hold_valid", {63'd0, res_valid}, 64'd1);
      check("empty_hold_key", {32'd0, res_key}, {32'd0, hk});
    end
    check("empty_no_strobe", 64'(node_strobes - s0), 64'd0);
    stall_res = 0;
    wait_drain();

    // Fill to capacity, then node_full blocking below capacity
    s0 = node_strobes;
    repeat (CAP) do_cmd(1, $urandom);
    wait_drain();
    enq_valid = 1;
    #1;
    check("cap_enq_ready", {63'd0, enq_ready}, 64'd0);
    check("cap_count", {59'd0, count}, 64'(CAP));
    enq_valid = 0;
    repeat (CAP - 10) do_cmd(0, 0);
    wait_drain();
    force_full = 1;
    @(negedge clk); #1;
    enq_valid = 1;
    #1;
    check("full_enq_ready", {63'd0, enq_ready}, 64'd0);
    check("full_deq_ready", {63'd0, deq_ready}, 64'd1);
    check("full_count", {59'd0, count}, 64'd10);
    enq_valid = 0; force_full = 0;
    repeat (10) do_cmd(0, 0);
    wait_drain();
    check("fill_strobes", 64'(node_strobes - s0), 64'(2 * CAP));

    // Contested requests alternate starting with dequeue
    for (int n = 0; n < 10; n++) begin
      k = $urandom; g = 0; t = 0;
      @(negedge clk);
      enq_valid = 1; deq_valid = 1; enq_key = k;
      while (!g && t < 300) begin
        #1;
        if (enq_ready || deq_ready) g = 1;
        else begin @(negedge clk); t++; end
      end
      check("contest_grant", {63'd0, g}, 64'd1);
      if (g) begin
        check("contest_winner_deq", {63'd0, deq_ready}, {63'd0, exp_deq_turn});
        check("contest_single", {63'd0, enq_ready & deq_ready}, 64'd0);
        model_grant(enq_ready, k);
        exp_deq_turn = !exp_deq_turn;
      end
      @(negedge clk);
      enq_valid = 0; deq_valid = 0;
      #1 check("contest_count", {59'd0, count}, 64'(ref_q.size()));
    end
    wait_drain();

    // Node never returns rdy: error after exactly TIMEOUT wait cycles
    stall = 1;
    do_cmd(1, 32'h42);
    repeat (60) @(negedge clk);
    #1 check("timeout_early", {63'd0, timeout_err}, 64'd0);
    repeat (10) @(negedge clk);
    #1 check("timeout_err", {63'd0, timeout_err}, 64'd1);
    enq_valid = 1; deq_valid = 1;
    repeat (3) begin
      @(negedge clk); #1;
      check("err_enq_ready", {63'd0, enq_ready}, 64'd0);
      check("err_deq_ready", {63'd0, deq_ready}, 64'd0);
    end
    enq_valid = 0; deq_valid = 0;
    reset_dut();
    @(negedge clk); #1;
    check("err_cleared", {63'd0, timeout_err}, 64'd0);
    check("err_cleared_ready", {63'd0, deq_ready}, 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
